// File: rtl/cascade_pkg.sv
// cascade_pkg: shared cascade widths and the stage accumulator state encoding
package cascade_pkg;
  localparam int W_LEAF = 13;
  localparam int STAGE_NUM = 25;
  localparam int MAX_STAGE_FEAT = 211;
  localparam int W_CNT = $clog2(MAX_STAGE_FEAT + 1);
  localparam int W_ACC = W_LEAF + W_CNT;
  localparam int W_STAGE = $clog2(STAGE_NUM);
  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;
endpackage

// File: rtl/stage_accum.sv
// stage_accum: sums one stage's signed leaves, compares against threshold, reports pass/done per stage
module stage_accum #(
  parameter int W_LEAF = cascade_pkg::W_LEAF,
  parameter int STAGE_NUM = cascade_pkg::STAGE_NUM,
  parameter int MAX_STAGE_FEAT = cascade_pkg::MAX_STAGE_FEAT,
  localparam int W_CNT = $clog2(MAX_STAGE_FEAT + 1),
  localparam int W_ACC = W_LEAF + W_CNT,
  localparam int W_STAGE = $clog2(STAGE_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               stage_valid,
  output logic               stage_ready,
  input  logic [W_CNT-1:0]   stage_feat_num,
  input  logic [W_ACC-1:0]   stage_thr,
  input  logic               leaf_valid,
  output logic               leaf_ready,
  input  logic [W_LEAF-1:0]  leaf_data,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               result_pass,
  output logic [W_STAGE-1:0] result_stage,
  output logic               result_done
);
  import cascade_pkg::*;
  state_t state;
  logic [W_ACC-1:0] acc, thr, acc_sum, res_acc, res_thr;
  logic [W_CNT-1:0] cnt;
  logic [W_STAGE-1:0] stage_idx;
  logic to_res, pass_nxt, done_nxt;
  assign stage_ready = state == IDLE;
  assign leaf_ready = state == ACCUM;
  assign result_valid = state == RESULT;
  // A zero-feature stage enters RESULT straight from IDLE with sum 0 against the incoming threshold
  always_comb begin
    acc_sum = acc + {{(W_ACC-W_LEAF){leaf_data[W_LEAF-1]}}, leaf_data};
    res_acc = state == IDLE ? '0 : acc_sum;
    res_thr = state == IDLE ? stage_thr : thr;
    pass_nxt = $signed(res_acc) >= $signed(res_thr);
    done_nxt = !pass_nxt || stage_idx == W_STAGE'(STAGE_NUM - 1);
    to_res = (state == IDLE && stage_valid && stage_feat_num == '0) ||
             (state == ACCUM && leaf_valid && cnt == W_CNT'(1));
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
      acc <= '0;
      thr <= '0;
      cnt <= '0;
      stage_idx <= '0;
      result_pass <= 1'b0;
      result_stage <= '0;
      result_done <= 1'b0;
    end else begin
      if (state == IDLE && stage_valid) begin
        thr <= stage_thr;
        cnt <= stage_feat_num;
        acc <= '0;
        state <= stage_feat_num == '0 ? RESULT : ACCUM;
      end
      if (state == ACCUM && leaf_valid) begin
        acc <= acc_sum;
        cnt <= cnt - W_CNT'(1);
        if (cnt == W_CNT'(1)) state <= RESULT;
      end
      if (state == RESULT && result_ready) begin
        stage_idx <= result_done ? '0 : stage_idx + W_STAGE'(1);
        state <= IDLE;
      end
      if (to_res) begin
        result_pass <= pass_nxt;
        result_stage <= stage_idx;
        result_done <= done_nxt;
      end
    end
  end
  feat_num_legal: assert property (@(posedge clk) disable iff (rst)
    stage_valid && stage_ready |-> stage_feat_num <= W_CNT'(MAX_STAGE_FEAT));
endmodule

// File: tb/tb_stage_accum.sv
// tb_stage_accum: directed self-checking bench for stage_accum with a 3-stage cascade
module tb_stage_accum;
  localparam int W_LEAF = 13;
  localparam int STAGE_NUM = 3;
  localparam int MAX_STAGE_FEAT = 211;
  localparam int W_CNT = 8;
  localparam int W_ACC = 21;
  localparam int W_STAGE = 2;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic stage_valid = 1'b0, stage_ready;
  logic [W_CNT-1:0] stage_feat_num = '0;
  logic [W_ACC-1:0] stage_thr = '0;
  logic leaf_valid = 1'b0, leaf_ready;
  logic [W_LEAF-1:0] leaf_data = '0;
  logic result_valid, result_ready = 1'b0, result_pass, result_done;
  logic [W_STAGE-1:0] result_stage;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  stage_accum #(.W_LEAF(W_LEAF), .STAGE_NUM(STAGE_NUM), .MAX_STAGE_FEAT(MAX_STAGE_FEAT)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .stage_valid(stage_valid), .stage_ready(stage_ready),
    .stage_feat_num(stage_feat_num), .stage_thr(stage_thr),
    .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .leaf_data(leaf_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_pass(result_pass), .result_stage(result_stage), .result_done(result_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_res(input string tag, input logic pass, input int stage, input logic done);
    chk({tag, "_valid"}, 32'(result_valid), 1);
    chk({tag, "_pass"}, 32'(result_pass), 32'(pass));
    chk({tag, "_stage"}, 32'(result_stage), 32'(stage));
    chk({tag, "_done"}, 32'(result_done), 32'(done));
  endtask
  task automatic send_stage(input int n, input int thr);
    int k = 0;
    stage_valid = 1'b1;
    stage_feat_num = W_CNT'(n);
    stage_thr = W_ACC'(thr);
    while (!stage_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (k == 20) chk("stage_timeout", 32'(stage_ready), 1);
    else begin @(posedge clk); #1; end
    stage_valid = 1'b0;
  endtask
  task automatic send_leaf(input int v);
    int k = 0;
    leaf_valid = 1'b1;
    leaf_data = W_LEAF'(v);
    while (!leaf_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (k == 20) chk("leaf_timeout", 32'(leaf_ready), 1);
    else begin @(posedge clk); #1; end
    leaf_valid = 1'b0;
  endtask
  task automatic take_result();
    int k = 0;
    result_ready = 1'b1;
    while (!result_valid && k < 20) begin @(posedge clk); #1; k++; end
    if (k == 20) chk("result_timeout", 32'(result_valid), 1);
    else begin @(posedge clk); #1; end
    result_ready = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_stage_ready", 32'(stage_ready), 1);
    chk("rst_leaf_ready", 32'(leaf_ready), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_pass", 32'(result_pass), 0);
    chk("rst_stage", 32'(result_stage), 0);
    chk("rst_done", 32'(result_done), 0);
    send_stage(3, 10);
    chk("t1_leaf_ready", 32'(leaf_ready), 1);
    chk("t1_stage_ready", 32'(stage_ready), 0);
    send_leaf(4);
    send_leaf(5);
    chk("t1_not_yet", 32'(result_valid), 0);
    send_leaf(1);
    chk_res("t1", 1'b1, 0, 1'b0);
    take_result();
    send_stage(2, 0);
    send_leaf(-3);
    send_leaf(2);
    chk_res("t2", 1'b0, 1, 1'b1);
    take_result();
    for (int s = 0; s < 3; s++) begin
      send_stage(1, 0);
      send_leaf(5);
      chk_res("t3", 1'b1, s, s == 2);
      take_result();
    end
    send_stage(0, 0);
    chk("t4_leaf_ready", 32'(leaf_ready), 0);
    chk_res("t4a", 1'b1, 0, 1'b0);
    take_result();
    send_stage(0, 1);
    chk_res("t4b", 1'b0, 1, 1'b1);
    take_result();
    send_stage(1, 100);
    send_leaf(7);
    stage_valid = 1'b1;
    stage_feat_num = W_CNT'(2);
    stage_thr = W_ACC'(-5);
    for (int i = 0; i < 5; i++) begin
      chk_res("t5_hold", 1'b0, 0, 1'b1);
      chk("t5_leaf_ready", 32'(leaf_ready), 0);
      chk("t5_stage_ready", 32'(stage_ready), 0);
      @(posedge clk); #1;
    end
    take_result();
    chk("t5_pending_ready", 32'(stage_ready), 1);
    send_stage(2, -5);
    send_leaf(-1);
    send_leaf(-4);
    chk_res("t5_tie", 1'b1, 0, 1'b0);
    take_result();
    send_stage(5, 0);
    send_leaf(9);
    send_leaf(9);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("t6_stage_ready", 32'(stage_ready), 1);
    chk("t6_leaf_ready", 32'(leaf_ready), 0);
    chk("t6_result_valid", 32'(result_valid), 0);
    send_stage(2, 3);
    send_leaf(1);
    send_leaf(2);
    chk_res("t6", 1'b1, 0, 1'b0);
    take_result();
    send_stage(211, -864256);
    for (int i = 0; i < 211; i++) send_leaf(-4096);
    chk_res("ext_tie", 1'b1, 1, 1'b0);
    take_result();
    send_stage(211, -864255);
    for (int i = 0; i < 211; i++) send_leaf(-4096);
    chk_res("ext_fail", 1'b0, 2, 1'b1);
    take_result();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
